// File: rtl/fifo_wr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_arb_pkg
// Purpose  : Shared types and constants for the FIFO write-port arbiter:
//            FSM state encoding, default word width, and the widths of the
//            beat, owner-index and stall counters.
// Revision : 1.0  initial release
// ============================================================================
package fifo_arb_pkg;

    localparam int c_DATA_W  = 8;   // default word width, matches the team FIFO
    localparam int c_CNT_W   = 4;   // beat counter width (MAX_BURST up to 15)
    localparam int c_ID_W    = 3;   // requester index width (N up to 8)
    localparam int c_STALL_W = 5;   // stall watchdog counter width

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : rr_picker
// Purpose  : Purely combinational round-robin find-first. Searches i_req
//            starting at i_last+1 and wrapping modulo N.
// Ports    : i_req  [N]   request vector
//            i_last [3]   index of the previous owner (must be < N)
//            o_any        at least one request present
//            o_idx  [3]   index of the winning requester (0 when !o_any)
// Revision : 1.0  initial release
// ============================================================================
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]        i_req,
    input  logic [c_ID_W-1:0]   i_last,
    output logic                o_any,
    output logic [c_ID_W-1:0]   o_idx
);

    // Candidate k is the requester at search distance k+1 from the last owner.
    logic [c_ID_W-1:0] w_cand [N];

    for (genvar k = 0; k < N; k++) begin : g_cand
        assign w_cand[k] = c_ID_W'((int'(i_last) + k + 1) % N);
    end

    // Walk from the farthest candidate to the nearest so the nearest hit
    // is the one left standing.
    always_comb begin
        o_any = 1'b0;
        o_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            for (int j = 0; j < N; j++) begin
                if ((w_cand[k] == c_ID_W'(j)) && i_req[j]) begin
                    o_any = 1'b1;
                    o_idx = w_cand[k];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Purpose  : Shares the FIFO write port (WR_EN/FIFO_IN/FULL) among N
//            producers with round-robin arbitration and bounded bursts.
//            A granted producer keeps the port until it drops REQ or has
//            written MAX_BURST words; each new grant costs one IDLE cycle.
// Ports    : SYSCLK           clock, rising edge
//            RST              synchronous reset, active high
//            REQ      [N]     per-requester valid word
//            REQ_DATA [N*W]   requester i word at [i*W +: W]
//            GNT      [N]     one-hot, word of requester i accepted
//            FULL             FIFO full flag
//            WR_EN            FIFO write enable
//            FIFO_IN  [W]     FIFO write data (0 when WR_EN=0)
//            BUSY             arbiter is in BURST
//            CUR_ID   [3]     owning requester, valid while BUSY
//            STALL_ERR        one-cycle pulse when a burst is abandoned
// Options  : FIFO_ARB_WDOG_EN  enables the FULL-stall watchdog; without it
//                              stalls last indefinitely and STALL_ERR=0.
// Revision : 1.0  initial release
// ============================================================================
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N           = 4,
    parameter int DATA_W      = c_DATA_W,
    parameter int MAX_BURST   = 4,
    parameter int STALL_LIMIT = 16
) (
    input  logic                  SYSCLK,
    input  logic                  RST,
    input  logic [N-1:0]          REQ,
    input  logic [N*DATA_W-1:0]   REQ_DATA,
    output logic [N-1:0]          GNT,
    input  logic                  FULL,
    output logic                  WR_EN,
    output logic [DATA_W-1:0]     FIFO_IN,
    output logic                  BUSY,
    output logic [2:0]            CUR_ID,
    output logic                  STALL_ERR
);

    // ------------------------------------------------------------------
    // Parameter range guards
    // ------------------------------------------------------------------
    if (N < 2 || N > 8) begin : g_chk_n
        $error("fifo_wr_arbiter: N must be in 2..8");
    end
    if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_chk_burst
        $error("fifo_wr_arbiter: MAX_BURST must be in 1..15");
    end
    if (STALL_LIMIT < 1 || STALL_LIMIT > 31) begin : g_chk_stall
        $error("fifo_wr_arbiter: STALL_LIMIT must be in 1..31");
    end

    // Comparing the pre-increment count against MAX_BURST-1 is the same
    // test as "beat_cnt+1 == MAX_BURST" without a wider adder.
    localparam logic [c_CNT_W-1:0] c_BEAT_LAST = c_CNT_W'(MAX_BURST - 1);
    // Last owner resets to N-1 so requester 0 is searched first.
    localparam logic [c_ID_W-1:0]  c_LAST_RST  = c_ID_W'(N - 1);

    arb_state_t             r_state,    w_state_nxt;
    logic [c_ID_W-1:0]      r_cur,      w_cur_nxt;
    logic [c_ID_W-1:0]      r_last,     w_last_nxt;
    logic [c_CNT_W-1:0]     r_beat_cnt, w_beat_nxt;

    logic                   w_pick_any;
    logic [c_ID_W-1:0]      w_pick_idx;
    logic                   w_own_req;
    logic [DATA_W-1:0]      w_own_data;
    logic                   w_burst;
    logic                   w_wr;
    logic                   w_abandon;

    // ------------------------------------------------------------------
    // Round-robin search
    // ------------------------------------------------------------------
    rr_picker #(
        .N      (N)
    ) u_picker (
        .i_req  (REQ),
        .i_last (r_last),
        .o_any  (w_pick_any),
        .o_idx  (w_pick_idx)
    );

    // ------------------------------------------------------------------
    // Owner's request and data; non-owner slices are ignored.
    // ------------------------------------------------------------------
    always_comb begin
        w_own_req  = 1'b0;
        w_own_data = '0;
        for (int i = 0; i < N; i++) begin
            if (r_cur == c_ID_W'(i)) begin
                w_own_req  = REQ[i];
                w_own_data = REQ_DATA[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_burst = (r_state == ST_BURST);
    // RST gates the write path so a reset mid-burst never leaks a word.
    assign w_wr    = w_burst & w_own_req & ~FULL & ~RST;

    for (genvar i = 0; i < N; i++) begin : g_gnt
        assign GNT[i] = w_wr & (r_cur == c_ID_W'(i));
    end

    assign WR_EN   = w_wr;
    assign FIFO_IN = w_wr ? w_own_data : '0;
    assign BUSY    = w_burst;
    assign CUR_ID  = r_cur;

    // ------------------------------------------------------------------
    // FULL-stall watchdog
    // ------------------------------------------------------------------
`ifdef FIFO_ARB_WDOG_EN
    localparam logic [c_STALL_W-1:0] c_STALL_LAST = c_STALL_W'(STALL_LIMIT - 1);

    logic [c_STALL_W-1:0]   r_stall_cnt, w_stall_nxt;
    logic                   w_stalling;

    assign w_stalling = w_burst & w_own_req & FULL;
    // The cycle that would bring the count to STALL_LIMIT is the abandon cycle.
    assign w_abandon  = w_stalling & (r_stall_cnt == c_STALL_LAST);
    assign STALL_ERR  = w_abandon & ~RST;

    // Counter only survives consecutive stall cycles; any write, idle
    // cycle or abandon clears it.
    always_comb begin
        w_stall_nxt = '0;
        if (w_stalling && !w_abandon) begin
            w_stall_nxt = r_stall_cnt + 1'b1;
        end
    end

    always_ff @(posedge SYSCLK) begin
        if (RST) begin
            r_stall_cnt <= '0;
        end else begin
            r_stall_cnt <= w_stall_nxt;
        end
    end
`else
    assign w_abandon = 1'b0;
    assign STALL_ERR = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cur_nxt   = r_cur;
        w_last_nxt  = r_last;
        w_beat_nxt  = r_beat_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_any) begin
                    w_state_nxt = ST_BURST;
                    w_cur_nxt   = w_pick_idx;
                    w_beat_nxt  = '0;
                end
            end
            ST_BURST: begin
                // Owner releasing the port wins over every other condition.
                if (!w_own_req) begin
                    w_state_nxt = ST_IDLE;
                    w_last_nxt  = r_cur;
                end else if (w_wr) begin
                    w_beat_nxt = r_beat_cnt + 1'b1;
                    if (r_beat_cnt == c_BEAT_LAST) begin
                        w_state_nxt = ST_IDLE;
                        w_last_nxt  = r_cur;
                    end
                end else if (w_abandon) begin
                    w_state_nxt = ST_IDLE;
                    w_last_nxt  = r_cur;
                end
                // Otherwise stalled on FULL: hold owner and beat count.
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge SYSCLK) begin
        if (RST) begin
            r_state    <= ST_IDLE;
            r_cur      <= '0;
            r_last     <= c_LAST_RST;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cur      <= w_cur_nxt;
            r_last     <= w_last_nxt;
            r_beat_cnt <= w_beat_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_wr_arbiter
// Purpose  : Self-checking bench for fifo_wr_arbiter. Four producer models
//            feed word lists; directed scenarios push the expected writes
//            (owner, data, cycle) into a reference queue; a monitor pops and
//            compares on every WR_EN. Watchdog scenario runs only when
//            FIFO_ARB_WDOG_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic             SYSCLK = 1'b0;
    logic             RST;
    logic [N-1:0]     REQ;
    logic [N*W-1:0]   REQ_DATA;
    logic [N-1:0]     GNT;
    logic             FULL;
    logic             WR_EN;
    logic [W-1:0]     FIFO_IN;
    logic             BUSY;
    logic [2:0]       CUR_ID;
    logic             STALL_ERR;

    fifo_wr_arbiter dut (
        .SYSCLK    (SYSCLK),
        .RST       (RST),
        .REQ       (REQ),
        .REQ_DATA  (REQ_DATA),
        .GNT       (GNT),
        .FULL      (FULL),
        .WR_EN     (WR_EN),
        .FIFO_IN   (FIFO_IN),
        .BUSY      (BUSY),
        .CUR_ID    (CUR_ID),
        .STALL_ERR (STALL_ERR)
    );

    always #5 SYSCLK = ~SYSCLK;

    int cyc = 0;
    always @(posedge SYSCLK) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Producer models: word list per requester, REQ while words remain.
    // ------------------------------------------------------------------
    logic [7:0] mem [N][256];
    logic [7:0] wr_p [N] = '{0, 0, 0, 0};
    logic [7:0] rd_p [N] = '{0, 0, 0, 0};
    logic [N-1:0] g_lat = '0;

    always_comb begin
        REQ      = '0;
        REQ_DATA = '0;
        for (int i = 0; i < N; i++) begin
            REQ[i]          = (rd_p[i] != wr_p[i]);
            REQ_DATA[i*W +: W] = mem[i][rd_p[i]];
        end
    end

    always @(negedge SYSCLK) g_lat = GNT;

    always @(posedge SYSCLK) begin
        #1;
        for (int i = 0; i < N; i++) begin
            if (g_lat[i] === 1'b1) rd_p[i] = rd_p[i] + 8'd1;
        end
    end

    task automatic load(input int i, input logic [7:0] d);
        mem[i][wr_p[i]] = d;
        wr_p[i] = wr_p[i] + 8'd1;
    endtask

    // ------------------------------------------------------------------
    // Reference queue and monitor
    // ------------------------------------------------------------------
    typedef struct {
        int         id;
        logic [7:0] data;
        int         c;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    bit   mon_on = 1'b0;

    task automatic expw(input int id, input logic [7:0] d, input int c);
        exp_t e;
        e.id = id; e.data = d; e.c = c;
        exp_q.push_back(e);
    endtask

    always @(negedge SYSCLK) begin
        if (mon_on) begin
            if (WR_EN === 1'b1) begin
                chk("no_overflow", 32'(FULL), 0);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: cyc=%0d gnt=%0h data=%0h want no write", cyc, GNT, FIFO_IN);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("wr_cycle", cyc, mon_e.c);
                    chk("wr_data", 32'(FIFO_IN), 32'(mon_e.data));
                    chk("wr_gnt", 32'(GNT), 32'(1) << mon_e.id);
                    chk("wr_cur_id", 32'(CUR_ID), mon_e.id);
                end
            end else begin
                chk("idle_gnt", 32'(GNT), 0);
                chk("idle_data", 32'(FIFO_IN), 0);
            end
`ifndef FIFO_ARB_WDOG_EN
            chk("stall_err_off", 32'(STALL_ERR), 0);
`endif
        end
    end

    task automatic tick();
        @(posedge SYSCLK);
        #1;
    endtask

    initial begin
        #60000;
        $display("FAIL timeout: cyc=%0d got=running want=finished", cyc);
        $fatal(1, "timeout");
    end

    // ------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------
    int s;

    initial begin
        RST  = 1'b1;
        FULL = 1'b0;
        tick();
        mon_on = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        @(negedge SYSCLK);
        chk("rst_busy", 32'(BUSY), 0);
        chk("rst_cur_id", 32'(CUR_ID), 0);
        chk("rst_wr_en", 32'(WR_EN), 0);
        chk("rst_gnt", 32'(GNT), 0);

        // All four requesting: order 0,1,2,3,0, 4 beats each, one bubble.
        tick();
        s = cyc;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < ((i == 0) ? 8 : 4); j++) load(i, 8'(32 + i*16 + j));
        end
        for (int b = 0; b < 5; b++) begin
            for (int k = 0; k < 4; k++) begin
                expw(b % 4, 8'(32 + (b % 4)*16 + ((b == 4) ? 4 : 0) + k), s + 1 + 5*b + k);
            end
        end
        repeat (30) tick();

        // Single requester, 6 words: 4 beats, bubble, 2 beats.
        s = cyc;
        for (int j = 0; j < 6; j++) load(0, 8'(16 + j));
        expw(0, 8'h10, s + 1);
        expw(0, 8'h11, s + 2);
        expw(0, 8'h12, s + 3);
        expw(0, 8'h13, s + 4);
        expw(0, 8'h14, s + 6);
        expw(0, 8'h15, s + 7);
        repeat (12) tick();

        // Early release: 1 drops after 2 words; 3 takes over, then 0.
        s = cyc;
        load(1, 8'h40); load(1, 8'h41);
        load(3, 8'h50); load(3, 8'h51); load(3, 8'h52);
        load(0, 8'h60);
        expw(1, 8'h40, s + 1);
        expw(1, 8'h41, s + 2);
        expw(3, 8'h50, s + 5);
        expw(3, 8'h51, s + 6);
        expw(3, 8'h52, s + 7);
        expw(0, 8'h60, s + 10);
        tick(); tick(); tick();
        @(negedge SYSCLK);
        chk("release_busy_hold", 32'(BUSY), 1);
        tick();
        @(negedge SYSCLK);
        chk("release_idle", 32'(BUSY), 0);
        tick();
        @(negedge SYSCLK);
        chk("release_next_owner", 32'(CUR_ID), 3);
        repeat (10) tick();

        // FULL stall: requester 2, FULL for 5 cycles after its 2nd word.
        s = cyc;
        for (int j = 0; j < 6; j++) load(2, 8'(112 + j));
        expw(2, 8'h70, s + 1);
        expw(2, 8'h71, s + 2);
        expw(2, 8'h72, s + 8);
        expw(2, 8'h73, s + 9);
        expw(2, 8'h74, s + 11);
        expw(2, 8'h75, s + 12);
        tick(); tick(); tick();
        FULL = 1'b1;
        repeat (5) begin
            @(negedge SYSCLK);
            chk("stall_cur_id", 32'(CUR_ID), 2);
            chk("stall_busy", 32'(BUSY), 1);
            tick();
        end
        FULL = 1'b0;
        repeat (12) tick();

        // Reset during requester 3's 2nd beat; requester 0 wins afterwards.
        s = cyc;
        for (int j = 0; j < 4; j++) load(3, 8'(128 + j));
        load(0, 8'h90);
        expw(3, 8'h80, s + 1);
        expw(0, 8'h90, s + 4);
        expw(3, 8'h81, s + 7);
        expw(3, 8'h82, s + 8);
        expw(3, 8'h83, s + 9);
        tick(); tick();
        RST = 1'b1;
        @(negedge SYSCLK);
        chk("midrst_wr_en", 32'(WR_EN), 0);
        chk("midrst_gnt", 32'(GNT), 0);
        tick();
        RST = 1'b0;
        @(negedge SYSCLK);
        chk("midrst_busy", 32'(BUSY), 0);
        chk("midrst_cur_id", 32'(CUR_ID), 0);
        repeat (12) tick();

`ifdef FIFO_ARB_WDOG_EN
        // Watchdog: FULL held 20 cycles; abandon at stall cycle 16.
        s = cyc;
        load(1, 8'hA0); load(1, 8'hA1); load(1, 8'hA2);
        expw(1, 8'hA0, s + 1);
        expw(1, 8'hA1, s + 22);
        expw(1, 8'hA2, s + 23);
        tick(); tick();
        FULL = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge SYSCLK);
            chk("wdog_stall_err", 32'(STALL_ERR), (k == 16) ? 1 : 0);
            if (k == 17) chk("wdog_released", 32'(BUSY), 0);
            tick();
        end
        FULL = 1'b0;
        repeat (10) tick();
`endif

        repeat (3) tick();
        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the single 8-bit write port of the team FIFO (WR_EN/FIFO_IN/FULL) among N producers.
- Uses round-robin arbitration with bounded bursts: a granted producer keeps the port until it drops REQ or has written MAX_BURST words.
- Sits between producer blocks and the FIFO write side. The read side (RD_EN/FIFO_OUT/EMPTY) is untouched.

Parameters:
- N, 4: number of requesters (2..8).
- DATA_W, 8: word width; must match the FIFO.
- MAX_BURST, 4: maximum words per grant (1..15).
- STALL_LIMIT, 16: FULL-stall cycles before a burst is abandoned (used only with the optional feature).

Ports:
- SYSCLK  in  1  system clock; everything is on the rising edge.
- RST  in  1  synchronous reset, active-high.
- REQ  in  N  per-requester request; REQ[i]=1 means REQ_DATA slice i holds a valid word.
- REQ_DATA  in  N*DATA_W  word from requester i is at bits [i*DATA_W +: DATA_W].
- GNT  out  N  one-hot; GNT[i]=1 means requester i's word is accepted this cycle and it must advance its data.
- FULL  in  1  FIFO full flag.
- WR_EN  out  1  FIFO write enable.
- FIFO_IN  out  DATA_W  FIFO write data.
- BUSY  out  1  arbiter is in BURST.
- CUR_ID  out  3  index of the owning requester; valid while BUSY.
- STALL_ERR  out  1  one-cycle pulse when a burst is abandoned (tied to 0 without the optional feature).

Behaviour:
- State machine:
  - States are IDLE and BURST. Registers: state, cur (owner), last (last owner), beat_cnt.
- Reset (RST=1 at an edge):
  - state=IDLE, cur=0, last=N-1 (so requester 0 wins first), beat_cnt=0.
  - WR_EN, GNT and STALL_ERR are combinationally forced to 0 while RST=1, including mid-burst.
  - BUSY=0 and CUR_ID=0 after the edge.
- IDLE:
  - If REQ≠0: cur <= first i with REQ[i]=1, searching last+1, last+2, ... with wrap mod N. Then state <= BURST and beat_cnt <= 0.
  - Arbitration costs exactly one cycle. No word is written in IDLE.
- BURST, write path (combinational):
  - WR_EN = REQ[cur] & ~FULL.
  - GNT[cur] = WR_EN; all other GNT bits are 0.
  - FIFO_IN = REQ_DATA slice cur.
  - FIFO_IN = 0 whenever WR_EN=0.
- BURST, accepted beat (WR_EN=1):
  - beat_cnt++.
  - If beat_cnt+1 == MAX_BURST: state <= IDLE and last <= cur.
- BURST, REQ[cur]=0:
  - state <= IDLE and last <= cur. No write that cycle.
  - REQ[cur] low takes precedence over everything else that cycle.
- BURST, FULL=1 with REQ[cur]=1:
  - Stall: no write, beat_cnt frozen, ownership kept.
- Throughput:
  - Sustained, at most MAX_BURST words per MAX_BURST+1 cycles (one arbitration bubble per burst).
- Fairness:
  - A requester holding REQ waits at most (N-1) bursts.
  - Requests from other requesters arriving mid-burst never preempt the owner.
- REQ_DATA slices of non-owners are ignored. GNT is never asserted without a write.
- Overflow is impossible: WR_EN is never asserted while FULL=1.
- BUSY = (state==BURST). CUR_ID = cur, zero-extended.

Optional Feature:
- Macro: FIFO_ARB_WDOG_EN.
- Defined:
  - A 5-bit stall counter increments each BURST cycle with REQ[cur]=1 and FULL=1.
  - It clears on any write, on leaving BURST, and on RST.
  - When it reaches STALL_LIMIT: STALL_ERR pulses for 1 cycle, state <= IDLE, last <= cur, and the word is NOT written.
- Undefined:
  - No counter. Stalls last indefinitely. STALL_ERR is constant 0.

Decomposition:
- Package fifo_arb_pkg holds:
  - state encoding typedef (IDLE=1'b0, BURST=1'b1);
  - DATA_W default constant;
  - CNT_W=4 for beat_cnt.
- Sub-module rr_picker: purely combinational.
  - Inputs: req[N], last.
  - Outputs: any, idx.
  - Does the wrap-around find-first. It is instantiated once and unit-testable alone.
- Test bench: follows the team's existing FIFO bench structure.
  - FAKE_CPU-style driver: N producer models.
  - MONITOR-style checker: compares WR_EN/FIFO_IN against a reference queue.

Test Plan:
1. Single requester: after reset, REQ=4'b0001 with data 0x10..0x15, FULL=0. Expected: IDLE one cycle, writes 0x10,0x11,0x12,0x13, one bubble cycle, then 0x14,0x15. GNT[0] high exactly on those 6 cycles.
2. All four requesting continuously, MAX_BURST=4. Expected grant order 0,1,2,3,0. Each burst is 4 consecutive WR_EN cycles with one idle cycle between bursts.
3. FULL stall: requester 2 owns the port, FULL asserted after its 2nd word for 5 cycles. Expected: WR_EN=0 and GNT=0 during the stall, CUR_ID=2 held, words 3-4 written after FULL drops, burst length still 4.
4. Early release: requester 1 drops REQ after 2 words while requester 3 is requesting. Expected: return to IDLE, next owner is 3, not 2 or 0.
5. Reset mid-burst: RST=1 during requester 3's 2nd beat. Expected: WR_EN=0 that cycle, BUSY=0 after the edge, next grant goes to requester 0.
6. With FIFO_ARB_WDOG_EN and STALL_LIMIT=16: FULL held for 20 cycles during a burst. Expected: STALL_ERR pulses exactly once at stall cycle 16, the owner is released, and no write occurs.
